// File: rtl/serial_pkg.sv
// serial_pkg: tag layout shared by the serial decoupler and recoupler.
// A tag is {beat serial, element index}; the element index takes clog2(NUM_ELEMENTS) bits.
package serial_pkg;
    localparam int DEF_SERIAL_WIDTH = 8;
    localparam int DEF_NUM_ELEMENTS = 8;
    localparam int DEF_DATA_BITS    = $clog2(DEF_NUM_ELEMENTS);
    localparam int DEF_BEAT_BITS    = DEF_SERIAL_WIDTH - DEF_DATA_BITS;
    localparam int DEF_DEPTH        = 2 ** DEF_BEAT_BITS;

    typedef logic [DEF_BEAT_BITS-1:0] serial_beat_t;
    typedef logic [DEF_DATA_BITS-1:0] serial_elem_t;

    function automatic int data_bits(int num_elements);
        return $clog2(num_elements);
    endfunction

    function automatic int beat_bits(int num_elements, int serial_width);
        return serial_width - $clog2(num_elements);
    endfunction

    function automatic logic [31:0] tag_beat(logic [31:0] tag, int db);
        return tag >> db;
    endfunction

    function automatic logic [31:0] tag_elem(logic [31:0] tag, int db);
        return tag & ((32'd1 << db) - 32'd1);
    endfunction
endpackage

// File: rtl/serial_recoupler_if.sv
// serial_recoupler_if: tagged element stream (tagged_i) and reassembled beat (ndata_i) interfaces.
interface tagged_i #(
    parameter type data_t = logic [31:0],
    parameter int SERIAL_WIDTH = 8
);
    logic valid;
    logic ready;
    data_t data;
    logic keep;
    logic last;
    logic [SERIAL_WIDTH-1:0] tag;
    modport m (output valid, data, keep, last, tag, input ready);
    modport s (input valid, data, keep, last, tag, output ready);
endinterface

interface ndata_i #(
    parameter type data_t = logic [31:0],
    parameter int NUM_ELEMENTS = 8
);
    logic valid;
    logic ready;
    data_t data [NUM_ELEMENTS];
    logic [NUM_ELEMENTS-1:0] keep;
    logic last;
    modport m (output valid, data, keep, last, input ready);
    modport s (input valid, data, keep, last, output ready);
endinterface

// File: rtl/serial_reorder_buffer.sv
// serial_reorder_buffer: beat-indexed slot storage with per-slot occupancy.
// Many write ports (callers guarantee distinct slots), one row read/clear at the head.
module serial_reorder_buffer #(
    parameter type data_t = logic [31:0],
    parameter int NUM_ELEMENTS = 8,
    parameter int NUM_LANES = 8,
    parameter int BEAT_BITS = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en   [NUM_LANES],
    input  logic [BEAT_BITS-1:0]          wr_beat [NUM_LANES],
    input  logic [$clog2(NUM_ELEMENTS)-1:0] wr_elem [NUM_LANES],
    input  data_t                         wr_data [NUM_LANES],
    input  logic                          wr_keep [NUM_LANES],
    input  logic                          wr_last [NUM_LANES],
    output logic                          wr_free [NUM_LANES],
    input  logic [BEAT_BITS-1:0]          rd_beat,
    input  logic                          rd_clr,
    output logic                          rd_full,
    output data_t                         rd_data [NUM_ELEMENTS],
    output logic [NUM_ELEMENTS-1:0]       rd_keep,
    output logic                          rd_last
);
    localparam int DEPTH = 2 ** BEAT_BITS;

    data_t mem_data [DEPTH][NUM_ELEMENTS];
    logic [NUM_ELEMENTS-1:0] mem_keep [DEPTH];
    logic [NUM_ELEMENTS-1:0] mem_last [DEPTH];
    logic [NUM_ELEMENTS-1:0] occ [DEPTH];

    // A cleared row is full, so no write can target it in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) occ[r] <= '0;
        end else begin
            if (rd_clr) occ[rd_beat] <= '0;
            for (int l = 0; l < NUM_LANES; l++)
                if (wr_en[l]) occ[wr_beat[l]][wr_elem[l]] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (wr_en[l]) begin
                mem_data[wr_beat[l]][wr_elem[l]] <= wr_data[l];
                mem_keep[wr_beat[l]][wr_elem[l]] <= wr_keep[l];
                mem_last[wr_beat[l]][wr_elem[l]] <= wr_last[l];
            end
        end
    end

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) wr_free[l] = !occ[wr_beat[l]][wr_elem[l]];
        for (int i = 0; i < NUM_ELEMENTS; i++) rd_data[i] = mem_data[rd_beat][i];
    end

    assign rd_full = &occ[rd_beat];
    assign rd_keep = mem_keep[rd_beat];
    assign rd_last = |mem_last[rd_beat];
endmodule

// File: rtl/serial_recoupler.sv
// serial_recoupler: reassembles out-of-order tagged elements from many lanes
// into ndata beats emitted in strict beat-serial order.
module serial_recoupler
    import serial_pkg::*;
#(
    parameter type data_t = logic [31:0],
    parameter int NUM_ELEMENTS = 8,
    parameter int NUM_LANES = 8,
    parameter int SERIAL_WIDTH = 8
) (
    input logic clk,
    input logic rst_n,
    tagged_i.s  in [NUM_LANES],
    ndata_i.m   out
);
    localparam int DATA_BITS = data_bits(NUM_ELEMENTS);
    localparam int BEAT_BITS = beat_bits(NUM_ELEMENTS, SERIAL_WIDTH);

    logic [SERIAL_WIDTH-1:0] lane_tag [NUM_LANES];
    logic                    lane_ready [NUM_LANES];
    logic                    wr_en [NUM_LANES];
    logic [BEAT_BITS-1:0]    wr_beat [NUM_LANES];
    logic [DATA_BITS-1:0]    wr_elem [NUM_LANES];
    data_t                   wr_data [NUM_LANES];
    logic                    wr_keep [NUM_LANES];
    logic                    wr_last [NUM_LANES];
    logic                    wr_free [NUM_LANES];
    logic [BEAT_BITS-1:0]    head;
    logic                    row_full;
    data_t                   row_data [NUM_ELEMENTS];
    logic [NUM_ELEMENTS-1:0] row_keep;
    logic                    row_last;
    logic                    load;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign lane_tag[g]  = in[g].tag;
        assign wr_beat[g]   = BEAT_BITS'(tag_beat(32'(in[g].tag), DATA_BITS));
        assign wr_elem[g]   = DATA_BITS'(tag_elem(32'(in[g].tag), DATA_BITS));
        assign wr_data[g]   = in[g].data;
        assign wr_keep[g]   = in[g].keep;
        assign wr_last[g]   = in[g].last;
        assign wr_en[g]     = in[g].valid && lane_ready[g];
        assign in[g].ready  = lane_ready[g];
    end

    // Equal tags mean equal slots; the lowest lane wins regardless of valid
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_ready[l] = wr_free[l];
            for (int k = 0; k < l; k++) lane_ready[l] = lane_ready[l] && (lane_tag[k] != lane_tag[l]);
        end
    end

    serial_reorder_buffer #(
        .data_t(data_t),
        .NUM_ELEMENTS(NUM_ELEMENTS),
        .NUM_LANES(NUM_LANES),
        .BEAT_BITS(BEAT_BITS)
    ) u_rob (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_beat(wr_beat),
        .wr_elem(wr_elem),
        .wr_data(wr_data),
        .wr_keep(wr_keep),
        .wr_last(wr_last),
        .wr_free(wr_free),
        .rd_beat(head),
        .rd_clr(load),
        .rd_full(row_full),
        .rd_data(row_data),
        .rd_keep(row_keep),
        .rd_last(row_last)
    );

    assign load = row_full && (!out.valid || out.ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out.valid <= 1'b0;
            head      <= '0;
        end else if (load) begin
            out.valid <= 1'b1;
            out.data  <= row_data;
            out.keep  <= row_keep;
            out.last  <= row_last;
            head      <= head + BEAT_BITS'(1);
        end else if (out.ready) begin
            out.valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_serial_recoupler.sv
// tb_serial_recoupler: randomized bench checking beat reassembly against a
// per-serial model of what each beat must contain.
module tb_serial_recoupler;
    localparam int NE = 8, NL = 8, SW = 8, DEPTH = 32, STALL_MAX = 1000;

    typedef struct {
        logic [NE*32-1:0] data;
        logic [NE-1:0]    keep;
        logic             last;
        int               cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic out_ready = 1'b1;
    logic          lane_valid [NL];
    logic [SW-1:0] lane_tag [NL];
    logic [31:0]   lane_data [NL];
    logic          lane_keep [NL];
    logic          lane_last [NL];
    logic          lane_ready [NL];
    logic          acc [NL];
    int cyc = 0, errors = 0, checks = 0;
    int stall_cnt [NL];
    beat_t got_q [$];
    logic [31:0]   exp_data [64][NE];
    logic [NE-1:0] exp_keep [64];
    logic [NE-1:0] exp_elast [64];

    always #5 clk = ~clk;

    tagged_i in_if [NL] ();
    ndata_i out_if ();
    assign out_if.ready = out_ready;

    for (genvar g = 0; g < NL; g++) begin : g_lane
        assign in_if[g].valid = lane_valid[g];
        assign in_if[g].tag   = lane_tag[g];
        assign in_if[g].data  = lane_data[g];
        assign in_if[g].keep  = lane_keep[g];
        assign in_if[g].last  = lane_last[g];
        assign lane_ready[g]  = in_if[g].ready;
        // A duplicated tag inside the window would stall its lane forever
        assert property (@(posedge clk) disable iff (!rst_n) stall_cnt[g] < STALL_MAX)
            else $error("FAIL lane_stall lane %0d stalled %0d cycles, limit %0d", g, stall_cnt[g], STALL_MAX);
    end

    always @(posedge clk)
        for (int l = 0; l < NL; l++)
            stall_cnt[l] <= (rst_n && lane_valid[l] && !lane_ready[l]) ? stall_cnt[l] + 1 : 0;

    serial_recoupler dut (.clk(clk), .rst_n(rst_n), .in(in_if), .out(out_if));

    function automatic logic [NE*32-1:0] exp_pack(int s);
        logic [NE*32-1:0] v;
        for (int e = 0; e < NE; e++) v[e*32 +: 32] = exp_data[s][e];
        return v;
    endfunction

    function automatic logic [NE*32-1:0] out_pack();
        logic [NE*32-1:0] v;
        for (int e = 0; e < NE; e++) v[e*32 +: 32] = out_if.data[e];
        return v;
    endfunction

    // mode 0: random last bits, 1: exactly one last bit, 2: no last bits
    task automatic gen_beat(input int s, input int mode);
        for (int e = 0; e < NE; e++) exp_data[s][e] = $urandom;
        exp_keep[s]  = NE'($urandom);
        exp_elast[s] = mode == 0 ? NE'($urandom) : mode == 1 ? NE'(1) << $urandom_range(0, NE-1) : '0;
    endtask

    task automatic put(input int l, input int s, input int e);
        lane_valid[l] = 1'b1;
        lane_tag[l]   = SW'(s*NE + e);
        lane_data[l]  = exp_data[s][e];
        lane_keep[l]  = exp_keep[s][e];
        lane_last[l]  = exp_elast[s][e];
    endtask

    task automatic idle_lane(input int l);
        lane_valid[l] = 1'b0;
        lane_tag[l]   = SW'(8'h80 + l);
        lane_data[l]  = '0;
        lane_keep[l]  = 1'b0;
        lane_last[l]  = 1'b0;
    endtask

    task automatic idle_lanes();
        for (int l = 0; l < NL; l++) idle_lane(l);
    endtask

    task automatic shuffle(output int p [NL]);
        int j, t;
        for (int i = 0; i < NL; i++) p[i] = i;
        for (int i = 0; i < NL; i++) begin
            j = $urandom_range(i, NL-1);
            t = p[i]; p[i] = p[j]; p[j] = t;
        end
    endtask

    task automatic cycle();
        beat_t b;
        #1;
        for (int l = 0; l < NL; l++) acc[l] = lane_valid[l] && lane_ready[l];
        if (out_if.valid && out_if.ready) begin
            b.data = out_pack();
            b.keep = out_if.keep;
            b.last = out_if.last;
            b.cyc  = cyc;
            got_q.push_back(b);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        idle_lanes();
        cycle();
        cycle();
        rst_n = 1'b1;
        got_q.delete();
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) cycle();
    endtask

    task automatic test_reset();
        logic [NL-1:0] rdy;
        do_reset();
        #1;
        checks++;
        if (out_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_if.valid); end
        for (int l = 0; l < NL; l++) rdy[l] = lane_ready[l];
        checks++;
        if (rdy !== '1) begin errors++; $display("FAIL reset_ready: got %b expected %b", rdy, {NL{1'b1}}); end
    endtask

    task automatic test_in_order();
        logic [NL-1:0] a;
        do_reset();
        for (int e = 0; e < NE; e++) begin
            exp_data[0][e] = 32'(e*16);
            put(e, 0, e);
        end
        exp_keep[0] = '1;
        exp_elast[0] = 8'h80;
        for (int e = 0; e < NE; e++) put(e, 0, e);
        cycle();
        for (int l = 0; l < NL; l++) a[l] = acc[l];
        checks++;
        if (a !== '1) begin errors++; $display("FAIL inorder_accept: got %b expected ff", a); end
        idle_lanes();
        #1;
        checks++;
        if (out_if.valid !== 1'b0) begin errors++; $display("FAIL inorder_early: valid at N+1 got %b expected 0", out_if.valid); end
        cycle();
        checks++;
        if (out_if.valid !== 1'b1 || out_pack() !== 256'h00000070_00000060_00000050_00000040_00000030_00000020_00000010_00000000
            || out_if.keep !== 8'hff || out_if.last !== 1'b1)
            begin errors++; $display("FAIL inorder_beat: got v=%b d=%h k=%h l=%b expected v=1 d=70..00 k=ff l=1",
                out_if.valid, out_pack(), out_if.keep, out_if.last); end
        checks++;
        if (dut.head !== 5'd1) begin errors++; $display("FAIL inorder_head: got %0d expected 1", dut.head); end
        cycle();
    endtask

    task automatic test_reverse();
        int p [NL];
        logic early;
        do_reset();
        gen_beat(0, 0);
        gen_beat(1, 0);
        shuffle(p);
        for (int e = 0; e < NE; e++) put(p[e], 1, e);
        cycle();
        idle_lanes();
        early = 1'b0;
        repeat (4) begin
            if (out_if.valid !== 1'b0) early = 1'b1;
            cycle();
        end
        checks++;
        if (early !== 1'b0 || got_q.size() != 0) begin errors++; $display("FAIL reverse_hold: early=%b beats=%0d expected 0 and 0", early, got_q.size()); end
        shuffle(p);
        for (int e = 0; e < NE; e++) put(p[e], 0, e);
        cycle();
        idle_lanes();
        wait_beats(2, 20);
        checks++;
        if (got_q.size() != 2) begin errors++; $display("FAIL reverse_count: got %0d expected 2", got_q.size()); end
        else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_q[i].data !== exp_pack(i) || got_q[i].keep !== exp_keep[i] || got_q[i].last !== (|exp_elast[i]))
                    begin errors++; $display("FAIL reverse_beat%0d: got %h/%h/%b expected %h/%h/%b", i,
                        got_q[i].data, got_q[i].keep, got_q[i].last, exp_pack(i), exp_keep[i], |exp_elast[i]); end
            end
            checks++;
            if (got_q[1].cyc != got_q[0].cyc + 1) begin errors++; $display("FAIL reverse_gap: got cycle %0d expected %0d", got_q[1].cyc, got_q[0].cyc + 1); end
        end
    endtask

    task automatic test_backpressure();
        int p [NL];
        logic stable;
        do_reset();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            gen_beat(s, 0);
            shuffle(p);
            for (int e = 0; e < NE; e++) put(p[e], s, e);
            cycle();
        end
        idle_lanes();
        stable = 1'b1;
        repeat (10) begin
            if (out_if.valid !== 1'b1 || out_pack() !== exp_pack(0)) stable = 1'b0;
            cycle();
        end
        checks++;
        if (stable !== 1'b1 || got_q.size() != 0) begin errors++; $display("FAIL bp_hold: stable=%b beats=%0d expected 1 and 0", stable, got_q.size()); end
        out_ready = 1'b1;
        repeat (3) cycle();
        checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", got_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i].data !== exp_pack(i) || got_q[i].keep !== exp_keep[i] || got_q[i].last !== (|exp_elast[i])
                    || got_q[i].cyc != got_q[0].cyc + i)
                    begin errors++; $display("FAIL bp_beat%0d: got %h at cycle %0d expected %h at cycle %0d", i,
                        got_q[i].data, got_q[i].cyc, exp_pack(i), got_q[0].cyc + i); end
            end
        end
    endtask

    task automatic test_collision();
        int lanes [7] = '{0, 1, 2, 3, 4, 6, 7};
        int elems [7] = '{0, 1, 2, 4, 5, 6, 7};
        logic done;
        int acc_cyc;
        do_reset();
        gen_beat(0, 0);
        gen_beat(32, 0);
        put(2, 0, 3);
        put(5, 32, 3);
        #1;
        checks++;
        if (lane_ready[2] !== 1'b1 || lane_ready[5] !== 1'b0)
            begin errors++; $display("FAIL coll_arb: got r2=%b r5=%b expected r2=1 r5=0", lane_ready[2], lane_ready[5]); end
        lane_valid[2] = 1'b0;
        #1;
        checks++;
        if (lane_ready[5] !== 1'b0) begin errors++; $display("FAIL coll_novalid: got r5=%b expected 0", lane_ready[5]); end
        lane_valid[2] = 1'b1;
        cycle();
        checks++;
        if (acc[2] !== 1'b1 || acc[5] !== 1'b0) begin errors++; $display("FAIL coll_write: got a2=%b a5=%b expected 1 0", acc[2], acc[5]); end
        idle_lane(2);
        #1;
        checks++;
        if (lane_ready[5] !== 1'b0) begin errors++; $display("FAIL coll_occupied: got r5=%b expected 0", lane_ready[5]); end
        for (int i = 0; i < 7; i++) put(lanes[i], 0, elems[i]);
        cycle();
        for (int i = 0; i < 7; i++) idle_lane(lanes[i]);
        done = 1'b0;
        acc_cyc = -1;
        for (int i = 0; i < 10 && !done; i++) begin
            cycle();
            if (acc[5]) begin done = 1'b1; acc_cyc = cyc - 1; end
        end
        idle_lane(5);
        checks++;
        if (!done || got_q.size() != 1) begin errors++; $display("FAIL coll_release: accepted=%b beats=%0d expected 1 and 1", done, got_q.size()); end
        else begin
            checks++;
            if (got_q[0].data !== exp_pack(0) || got_q[0].keep !== exp_keep[0])
                begin errors++; $display("FAIL coll_beat0: got %h expected %h", got_q[0].data, exp_pack(0)); end
            checks++;
            if (acc_cyc != got_q[0].cyc) begin errors++; $display("FAIL coll_timing: lane5 accepted cycle %0d expected %0d", acc_cyc, got_q[0].cyc); end
        end
    endtask

    task automatic test_reset_mid();
        int p [NL];
        logic [NL-1:0] rdy;
        do_reset();
        gen_beat(0, 0);
        for (int e = 0; e < 5; e++) put(e, 0, e);
        cycle();
        idle_lanes();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        got_q.delete();
        for (int l = 0; l < NL; l++) lane_tag[l] = SW'(l);
        #1;
        checks++;
        if (out_if.valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", out_if.valid); end
        for (int l = 0; l < NL; l++) rdy[l] = lane_ready[l];
        checks++;
        if (rdy !== '1) begin errors++; $display("FAIL rmid_occ: ready got %b expected ff", rdy); end
        gen_beat(0, 0);
        shuffle(p);
        for (int e = 0; e < NE; e++) put(p[e], 0, e);
        cycle();
        idle_lanes();
        wait_beats(1, 10);
        checks++;
        if (got_q.size() != 1 || got_q[0].data !== exp_pack(0) || got_q[0].keep !== exp_keep[0] || got_q[0].last !== (|exp_elast[0]))
            begin errors++; $display("FAIL rmid_fresh: beats=%0d expected 1 with data %h", got_q.size(), exp_pack(0)); end
    endtask

    task automatic test_wrap();
        localparam int NB = 40;
        int pend [$];
        logic busy [NL];
        int budget;
        do_reset();
        for (int s = 0; s < NB; s++) gen_beat(s, s == NB-1 ? 1 : 2);
        for (int s = 0; s < NB; s++)
            for (int e = 0; e < NE; e++) pend.insert($urandom_range(0, pend.size()), s*NE + e);
        for (int l = 0; l < NL; l++) busy[l] = 1'b0;
        budget = 0;
        while (got_q.size() < NB && budget < 5000) begin
            out_ready = $urandom_range(0, 3) != 0;
            for (int l = 0; l < NL; l++) begin
                if (!busy[l]) begin
                    idle_lane(l);
                    lane_tag[l] = SW'($urandom);
                    if ($urandom_range(0, 3) != 0)
                        for (int i = 0; i < pend.size(); i++)
                            if (pend[i] / NE < got_q.size() + DEPTH) begin
                                put(l, pend[i] / NE, pend[i] % NE);
                                pend.delete(i);
                                busy[l] = 1'b1;
                                break;
                            end
                end
            end
            cycle();
            budget++;
            for (int l = 0; l < NL; l++) if (busy[l] && acc[l]) busy[l] = 1'b0;
        end
        idle_lanes();
        out_ready = 1'b1;
        checks++;
        if (got_q.size() != NB) begin errors++; $display("FAIL wrap_count: got %0d beats expected %0d", got_q.size(), NB); end
        for (int i = 0; i < got_q.size() && i < NB; i++) begin
            checks++;
            if (got_q[i].data !== exp_pack(i) || got_q[i].keep !== exp_keep[i] || got_q[i].last !== (|exp_elast[i]))
                begin errors++; $display("FAIL wrap_beat%0d: got %h/%h/%b expected %h/%h/%b", i,
                    got_q[i].data, got_q[i].keep, got_q[i].last, exp_pack(i), exp_keep[i], |exp_elast[i]); end
        end
    endtask

    initial begin
        idle_lanes();
        @(posedge clk);
        #1;
        test_reset();
        test_in_order();
        test_reverse();
        test_backpressure();
        test_collision();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
